// File: rtl/jelly_wb_decoder.sv
// Single-master to SLAVE_NUM-slave WISHBONE decoder; 1-cycle registered decode, then ack/data pass straight from the selected slave.
// Master holds stb until ack/err; optional JELLY_WB_DECODER_TIMEOUT_EN builds a stall timeout (code 10).
module jelly_wb_decoder #(
    parameter int                        SLAVE_NUM      = 5,
    parameter int                        WB_ADR_WIDTH   = 30,
    parameter int                        WB_DAT_WIDTH   = 32,
    parameter int                        WB_SEL_WIDTH   = WB_DAT_WIDTH / 8,
    parameter logic [32*SLAVE_NUM-1:0]   SLAVE_ADDR     = {SLAVE_NUM{32'h0}},
    parameter logic [32*SLAVE_NUM-1:0]   SLAVE_MASK     = {SLAVE_NUM{32'hffffffff}},
    parameter int                        TIMEOUT_CYCLES = 256
) (
    input  logic                              clk,
    input  logic                              reset,

    input  logic [WB_ADR_WIDTH-1:0]           s_wb_adr_i,
    input  logic [WB_DAT_WIDTH-1:0]           s_wb_dat_i,
    output logic [WB_DAT_WIDTH-1:0]           s_wb_dat_o,
    input  logic                              s_wb_we_i,
    input  logic [WB_SEL_WIDTH-1:0]           s_wb_sel_i,
    input  logic                              s_wb_stb_i,
    output logic                              s_wb_ack_o,
    output logic                              s_wb_err_o,

    output logic [WB_ADR_WIDTH-1:0]           m_wb_adr_o,
    output logic [WB_DAT_WIDTH-1:0]           m_wb_dat_o,
    output logic                              m_wb_we_o,
    output logic [WB_SEL_WIDTH-1:0]           m_wb_sel_o,
    output logic [SLAVE_NUM-1:0]              m_wb_stb_o,
    input  logic [SLAVE_NUM*WB_DAT_WIDTH-1:0] m_wb_dat_i,
    input  logic [SLAVE_NUM-1:0]              m_wb_ack_i,

    output logic [WB_ADR_WIDTH-1:0]           err_adr_o,
    output logic [1:0]                        err_code_o,
    output logic [7:0]                        err_count_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_ERROR  = 2'd2;

    logic [1:0]           state;
    logic [1:0]           state_next;
    logic [SLAVE_NUM-1:0] sel_q;
    logic [SLAVE_NUM-1:0] hit_sel;
    logic                 hit;
    logic                 sel_ack;
    logic                 timeout;
    logic                 fault;
    logic [1:0]           fault_code;
    logic [31:0]          byte_adr;

    assign byte_adr   = 32'({s_wb_adr_i, 2'b00});

    assign m_wb_adr_o = s_wb_adr_i;
    assign m_wb_dat_o = s_wb_dat_i;
    assign m_wb_we_o  = s_wb_we_i;
    assign m_wb_sel_o = s_wb_sel_i;

    // Lowest-index match wins when windows overlap.
    always_comb begin
        hit     = 1'b0;
        hit_sel = '0;
        for (int i = 0; i < SLAVE_NUM; i++) begin
            if (!hit && ((byte_adr & SLAVE_MASK[32*i +: 32]) == SLAVE_ADDR[32*i +: 32])) begin
                hit        = 1'b1;
                hit_sel[i] = 1'b1;
            end
        end
    end

    assign sel_ack = |(m_wb_ack_i & sel_q);

`ifdef JELLY_WB_DECODER_TIMEOUT_EN
    logic [15:0] timer;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (state != ST_ACCESS) begin
            timer <= '0;
        end else begin
            timer <= timer + 16'd1;
        end
    end

    assign timeout = (state == ST_ACCESS) && (timer == 16'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // An ack in the expiry cycle is checked first, so it beats the timeout.
    always_comb begin
        state_next = state;
        fault      = 1'b0;
        fault_code = 2'b00;
        case (state)
            ST_IDLE: begin
                if (s_wb_stb_i) begin
                    if (hit) begin
                        state_next = ST_ACCESS;
                    end else begin
                        state_next = ST_ERROR;
                        fault      = 1'b1;
                        fault_code = 2'b01;
                    end
                end
            end
            ST_ACCESS: begin
                if (sel_ack || !s_wb_stb_i) begin
                    state_next = ST_IDLE;
                end else if (timeout) begin
                    state_next = ST_ERROR;
                    fault      = 1'b1;
                    fault_code = 2'b10;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            sel_q       <= '0;
            err_adr_o   <= '0;
            err_code_o  <= 2'b00;
            err_count_o <= 8'd0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && s_wb_stb_i && hit) begin
                sel_q <= hit_sel;
            end
            if (fault) begin
                err_adr_o  <= s_wb_adr_i;
                err_code_o <= fault_code;
                if (err_count_o != 8'hff) begin
                    err_count_o <= err_count_o + 8'd1;
                end
            end
        end
    end

    assign m_wb_stb_o = (state == ST_ACCESS && s_wb_stb_i) ? sel_q : '0;
    assign s_wb_ack_o = (state == ST_ACCESS) && sel_ack;
    assign s_wb_err_o = (state == ST_ERROR);

    always_comb begin
        s_wb_dat_o = '0;
        if (state == ST_ACCESS) begin
            for (int i = 0; i < SLAVE_NUM; i++) begin
                if (sel_q[i]) begin
                    s_wb_dat_o = s_wb_dat_o | m_wb_dat_i[WB_DAT_WIDTH*i +: WB_DAT_WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_jelly_wb_decoder.sv
// Randomised bench for jelly_wb_decoder with a transaction-level expectation model and per-cycle output compare.
`timescale 1ns/1ps
module tb_jelly_wb_decoder;

    localparam int N = 3;
    localparam int T = 8;
    localparam logic [31:0] ADDR_T [N] = '{32'h0000_0000, 32'h1000_0000, 32'hffff_f200};
    localparam logic [31:0] MASK_T [N] = '{32'hf000_0000, 32'hf000_0000, 32'hffff_fff0};
`ifdef JELLY_WB_DECODER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [29:0]   s_wb_adr_i;
    logic [31:0]   s_wb_dat_i;
    logic [31:0]   s_wb_dat_o;
    logic          s_wb_we_i;
    logic [3:0]    s_wb_sel_i;
    logic          s_wb_stb_i;
    logic          s_wb_ack_o;
    logic          s_wb_err_o;
    logic [29:0]   m_wb_adr_o;
    logic [31:0]   m_wb_dat_o;
    logic          m_wb_we_o;
    logic [3:0]    m_wb_sel_o;
    logic [N-1:0]  m_wb_stb_o;
    logic [N*32-1:0] m_wb_dat_i;
    logic [N-1:0]  m_wb_ack_i;
    logic [29:0]   err_adr_o;
    logic [1:0]    err_code_o;
    logic [7:0]    err_count_o;

    jelly_wb_decoder #(
        .SLAVE_NUM      (N),
        .WB_ADR_WIDTH   (30),
        .WB_DAT_WIDTH   (32),
        .WB_SEL_WIDTH   (4),
        .SLAVE_ADDR     ({32'hffff_f200, 32'h1000_0000, 32'h0000_0000}),
        .SLAVE_MASK     ({32'hffff_fff0, 32'hf000_0000, 32'hf000_0000}),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .s_wb_adr_i  (s_wb_adr_i),
        .s_wb_dat_i  (s_wb_dat_i),
        .s_wb_dat_o  (s_wb_dat_o),
        .s_wb_we_i   (s_wb_we_i),
        .s_wb_sel_i  (s_wb_sel_i),
        .s_wb_stb_i  (s_wb_stb_i),
        .s_wb_ack_o  (s_wb_ack_o),
        .s_wb_err_o  (s_wb_err_o),
        .m_wb_adr_o  (m_wb_adr_o),
        .m_wb_dat_o  (m_wb_dat_o),
        .m_wb_we_o   (m_wb_we_o),
        .m_wb_sel_o  (m_wb_sel_o),
        .m_wb_stb_o  (m_wb_stb_o),
        .m_wb_dat_i  (m_wb_dat_i),
        .m_wb_ack_i  (m_wb_ack_i),
        .err_adr_o   (err_adr_o),
        .err_code_o  (err_code_o),
        .err_count_o (err_count_o)
    );

    always #5 clk = ~clk;

    // Slave models: ack lat[i] cycles after stb first seen (lat<0 never); rogue forces a stray ack.
    int          lat   [N];
    logic [31:0] rd    [N];
    logic        rogue [N];
    int          cnt   [N];

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) cnt[i] <= m_wb_stb_o[i] ? cnt[i] + 1 : 0;
    end

    always_comb begin
        m_wb_ack_i = '0;
        for (int i = 0; i < N; i++)
            m_wb_ack_i[i] = rogue[i] | (m_wb_stb_o[i] && lat[i] >= 0 && cnt[i] == lat[i]);
    end

    assign m_wb_dat_i = {rd[2], rd[1], rd[0]};

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          chk_en;
    bit          errregs_ok;
    logic        exp_ack, exp_err;
    logic [N-1:0] exp_stb;
    logic [31:0] exp_dat;
    logic [29:0] m_err_adr;
    logic [1:0]  m_err_code;
    int          m_err_cnt;
    int          cur_n;
    int          obs_ack_n, obs_err_n;
    logic [31:0] obs_ack_dat;
    logic [N-1:0] obs_stb1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic int target_of(input logic [31:0] b);
        for (int i = 0; i < N; i++)
            if ((b & MASK_T[i]) == ADDR_T[i]) return i;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle_exp();
        cur_n = -1; exp_ack = 1'b0; exp_err = 1'b0; exp_stb = '0; exp_dat = '0; errregs_ok = 1'b1;
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("ack", s_wb_ack_o, exp_ack);
                chk("err", s_wb_err_o, exp_err);
                chk("m_stb", m_wb_stb_o, exp_stb);
                chk("s_dat", s_wb_dat_o, exp_dat);
                chk("m_adr", m_wb_adr_o, s_wb_adr_i);
                chk("m_dat", m_wb_dat_o, s_wb_dat_i);
                chk("m_we", m_wb_we_o, s_wb_we_i);
                chk("m_sel", m_wb_sel_o, s_wb_sel_i);
                if (errregs_ok) begin
                    chk("err_adr", err_adr_o, m_err_adr);
                    chk("err_code", err_code_o, m_err_code);
                    chk("err_count", err_count_o, m_err_cnt);
                end
            end
            if (cur_n == 0) begin
                obs_ack_n = -1; obs_err_n = -1; obs_stb1 = '0; obs_ack_dat = '0;
            end
            if (cur_n >= 0) begin
                if (s_wb_ack_o && obs_ack_n < 0) begin obs_ack_n = cur_n; obs_ack_dat = s_wb_dat_o; end
                if (s_wb_err_o && obs_err_n < 0) obs_err_n = cur_n;
                if (cur_n == 1) obs_stb1 = m_wb_stb_o;
            end
        end
    endtask

    // One master access; expected outcome derived from the decode table, slave latency and timeout rule.
    task automatic txn(input logic [31:0] b, input logic we, input logic [3:0] be,
                       input logic [31:0] wd, input int hold);
        int tgt, done;
        bit is_err, abort;
        logic [1:0] code;
        tgt = target_of(b); is_err = 0; abort = 0; code = 2'b00; done = 1;
        if (tgt < 0) begin
            is_err = 1; code = 2'b01;
        end else if (lat[tgt] >= 0 && (!TO_EN || lat[tgt] <= T - 1)) begin
            done = lat[tgt] + 1;
        end else if (TO_EN) begin
            done = T + 1; is_err = 1; code = 2'b10;
        end else begin
            done = hold; abort = 1;
        end
        for (int i = 0; i < N; i++) begin
            rd[i]    = $urandom;
            rogue[i] = (i != tgt) && ($urandom_range(0, 1) == 1);
        end
        s_wb_adr_i = b[31:2]; s_wb_we_i = we; s_wb_sel_i = be; s_wb_dat_i = wd; s_wb_stb_i = 1'b1;
        for (int n = 0; n <= done; n++) begin
            cur_n = n; exp_ack = 1'b0; exp_err = 1'b0; exp_stb = '0; exp_dat = '0; errregs_ok = 1'b1;
            if (abort && n == done) s_wb_stb_i = 1'b0;
            if (is_err && n == done) begin
                exp_err = 1'b1; errregs_ok = 1'b0;
            end else if (n >= 1) begin
                exp_stb = (abort && n == done) ? '0 : N'(1 << tgt);
                exp_dat = rd[tgt];
                exp_ack = !abort && (n == done);
            end
            step();
        end
        if (is_err) begin
            m_err_adr = b[31:2]; m_err_code = code;
            if (m_err_cnt < 255) m_err_cnt++;
        end
        s_wb_stb_i = 1'b0;
        for (int i = 0; i < N; i++) rogue[i] = 1'b0;
        set_idle_exp();
    endtask

    task automatic idle_cycles(input int k);
        logic [31:0] r;
        for (int j = 0; j < k; j++) begin
            r = $urandom;
            s_wb_stb_i = 1'b0; s_wb_adr_i = r[29:0];
            for (int i = 0; i < N; i++) rogue[i] = ($urandom_range(0, 1) == 1);
            set_idle_exp();
            step();
        end
        for (int i = 0; i < N; i++) rogue[i] = 1'b0;
    endtask

    initial begin
        logic [31:0] r, b;
        reset = 1'b1;
        s_wb_adr_i = '0; s_wb_dat_i = '0; s_wb_we_i = 1'b0; s_wb_sel_i = '0; s_wb_stb_i = 1'b0;
        for (int i = 0; i < N; i++) begin lat[i] = 0; rd[i] = '0; rogue[i] = 1'b0; end
        m_err_adr = '0; m_err_code = 2'b00; m_err_cnt = 0;
        set_idle_exp();
        chk_en = 1'b1;
        fork compare_loop(); join_none
        #2;
        chk("rst_ack", s_wb_ack_o, 1'b0);
        chk("rst_stb", m_wb_stb_o, 3'b000);
        chk("rst_err_count", err_count_o, 8'd0);
        step(); step(); step();
        reset = 1'b0;
        idle_cycles(2);

        lat[0] = 2;
        txn(32'h0000_0010, 1'b0, 4'hf, 32'h0, 0);
        // Overwrite happens before the first ack so rd[0] is the pinned value.
        chk("rd0_ack_cycle", obs_ack_n, 3);
        chk("rd0_stb", obs_stb1, 3'b001);

        lat[0] = 2;
        b = 32'h0000_0010;
        rd[0] = 32'hdeadbeef;
        s_wb_adr_i = b[31:2]; s_wb_stb_i = 1'b1; s_wb_we_i = 1'b0; s_wb_sel_i = 4'hf;
        cur_n = 0; step();
        for (int n = 1; n <= 3; n++) begin
            cur_n = n; exp_stb = 3'b001; exp_dat = 32'hdeadbeef; exp_ack = (n == 3); step();
        end
        s_wb_stb_i = 1'b0; set_idle_exp();
        chk("rd0_data", obs_ack_dat, 32'hdeadbeef);
        idle_cycles(1);

        lat[1] = 0;
        txn(32'h1000_0010, 1'b1, 4'b0011, 32'h1234_5678, 0);
        chk("wr1_ack_cycle", obs_ack_n, 1);
        chk("wr1_stb", obs_stb1, 3'b010);
        idle_cycles(1);

        txn(32'h8000_0000, 1'b0, 4'hf, 32'h0, 0);
        chk("unmap_err_cycle", obs_err_n, 1);
        chk("unmap_code", err_code_o, 2'b01);
        chk("unmap_adr", err_adr_o, 30'h2000_0000);
        chk("unmap_count", err_count_o, 8'd1);
        idle_cycles(1);

        // Async reset two cycles into a slave1 access.
        lat[1] = 6; rd[1] = 32'hcafe_f00d;
        b = 32'h1000_0020;
        s_wb_adr_i = b[31:2]; s_wb_stb_i = 1'b1;
        cur_n = 0; step();
        cur_n = 1; exp_stb = 3'b010; exp_dat = 32'hcafe_f00d; step();
        chk_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst_ack", s_wb_ack_o, 1'b0);
        chk("arst_err", s_wb_err_o, 1'b0);
        chk("arst_dat", s_wb_dat_o, 32'h0);
        chk("arst_stb", m_wb_stb_o, 3'b000);
        chk("arst_err_adr", err_adr_o, 30'h0);
        chk("arst_err_code", err_code_o, 2'b00);
        chk("arst_err_count", err_count_o, 8'd0);
        step();
        s_wb_stb_i = 1'b0; reset = 1'b0;
        m_err_adr = '0; m_err_code = 2'b00; m_err_cnt = 0;
        set_idle_exp(); chk_en = 1'b1;
        step();
        lat[1] = 1;
        txn(32'h1000_0020, 1'b0, 4'hf, 32'h0, 0);
        chk("post_rst_ack_cycle", obs_ack_n, 2);
        idle_cycles(1);

        lat[2] = -1;
        txn(32'hffff_f204, 1'b0, 4'hf, 32'h0, 1000);
`ifdef JELLY_WB_DECODER_TIMEOUT_EN
        chk("to_err_cycle", obs_err_n, 9);
        chk("to_code", err_code_o, 2'b10);
        chk("to_adr", err_adr_o, 30'h3fff_fc81);
        idle_cycles(1);
        lat[2] = T - 1;
        txn(32'hffff_f204, 1'b0, 4'hf, 32'h0, 0);
        chk("expiry_ack_cycle", obs_ack_n, 8);
        chk("expiry_no_err", obs_err_n, -1);
        chk("expiry_count", err_count_o, 8'd1);
`else
        chk("hold_no_err", obs_err_n, -1);
        chk("hold_no_ack", obs_ack_n, -1);
        chk("hold_count", err_count_o, 8'd0);
`endif
        idle_cycles(1);

        for (int k = 0; k < 150; k++) begin
            r = $urandom;
            case ($urandom_range(0, 4))
                0: b = {4'h0, r[27:0]};
                1: b = {4'h1, r[27:0]};
                2: b = {28'hffff_f20, r[3:0]};
                3: b = {28'hffff_f21, r[3:0]};
                default: b = $urandom;
            endcase
            for (int i = 0; i < N; i++) lat[i] = $urandom_range(0, 10);
            r = $urandom;
            txn(b, r[0], r[7:4], $urandom, 0);
            idle_cycles($urandom_range(0, 2));
        end

        for (int k = 0; k < 300; k++) begin
            r = $urandom;
            txn({4'h4, r[27:0]}, 1'b0, 4'hf, 32'h0, 0);
        end
        chk("sat_count", err_count_o, 8'd255);
        idle_cycles(1);
`ifdef JELLY_WB_DECODER_TIMEOUT_EN
        lat[2] = -1;
        txn(32'hffff_f208, 1'b0, 4'hf, 32'h0, 0);
        chk("sat_to_code", err_code_o, 2'b10);
        chk("sat_to_adr", err_adr_o, 30'h3fff_fc82);
`else
        txn(32'h2000_0004, 1'b0, 4'hf, 32'h0, 0);
        chk("sat_un_code", err_code_o, 2'b01);
        chk("sat_un_adr", err_adr_o, 30'h0800_0001);
`endif
        chk("sat_hold", err_count_o, 8'd255);
        idle_cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jelly_wb_decoder.md
# jelly_wb_decoder

Parametrised, registered WISHBONE address decoder for the Jelly SoC. It is a single-master to N-slave bridge that replaces hand-written per-peripheral decode in top-level designs. Each access is decoded against a per-slave address/mask table, and the access is forwarded to exactly one slave. Unmapped accesses and (optionally) slave timeouts complete with a bus error and capture fault information for software.

## Interface
Parameters:
- SLAVE_NUM, 5, number of slave ports (1..16)
- WB_ADR_WIDTH, 30, word address width (bits [31:2] of the byte address)
- WB_DAT_WIDTH, 32, data width
- WB_SEL_WIDTH, WB_DAT_WIDTH/8, byte-select width
- SLAVE_ADDR, {SLAVE_NUM{32'h0}}, packed 32-bit byte base address per slave; slave i occupies bits [32*i+31:32*i]
- SLAVE_MASK, {SLAVE_NUM{32'hffffffff}}, packed 32-bit byte mask per slave
- TIMEOUT_CYCLES, 256, ACCESS cycles without ack before timeout (2..65535)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- s_wb_adr_i  in  WB_ADR_WIDTH  master word address
- s_wb_dat_i  in  WB_DAT_WIDTH  master write data
- s_wb_dat_o  out  WB_DAT_WIDTH  read data to master
- s_wb_we_i  in  1  write enable
- s_wb_sel_i  in  WB_SEL_WIDTH  byte selects
- s_wb_stb_i  in  1  strobe
- s_wb_ack_o  out  1  normal completion
- s_wb_err_o  out  1  error completion
- m_wb_adr_o  out  WB_ADR_WIDTH  shared slave address
- m_wb_dat_o  out  WB_DAT_WIDTH  shared write data
- m_wb_we_o  out  1  shared write enable
- m_wb_sel_o  out  WB_SEL_WIDTH  shared byte selects
- m_wb_stb_o  out  SLAVE_NUM  per-slave strobe, at most one bit high
- m_wb_dat_i  in  SLAVE_NUM*WB_DAT_WIDTH  packed slave read data
- m_wb_ack_i  in  SLAVE_NUM  per-slave ack
- err_adr_o  out  WB_ADR_WIDTH  word address of the last faulting access
- err_code_o  out  2  last fault: 00 none, 01 unmapped, 10 timeout
- err_count_o  out  8  fault count, saturates at 255

## Operation
- Match rule: slave i matches when ({s_wb_adr_i,2'b00} & MASK[i]) == ADDR[i], with the byte address zero-extended or truncated to 32 bits. On overlapping matches, the lowest index wins.
- m_wb_adr_o, m_wb_dat_o, m_wb_we_o and m_wb_sel_o are combinational pass-throughs of the master inputs.
- State machine:
  - IDLE:
    - s_wb_stb_i=1 with a match: register the one-hot select, clear the timer, go to ACCESS.
    - s_wb_stb_i=1 with no match: go to ERROR.
  - ACCESS:
    - m_wb_stb_o[sel]=s_wb_stb_i.
    - s_wb_ack_o=m_wb_ack_i[sel] and s_wb_dat_o=m_wb_dat_i[sel], both combinational.
    - On ack, go to IDLE.
    - If s_wb_stb_i drops (master abort), go to IDLE with no ack.
    - If the timer reaches TIMEOUT_CYCLES-1 without ack: go to ERROR and record code 10.
  - ERROR: s_wb_err_o=1 for exactly one cycle, s_wb_dat_o=0, go to IDLE. Record err_adr_o=s_wb_adr_i and err_code_o, and increment err_count_o (saturating). For an unmapped access, err_code_o=01.
- Acks from non-selected slaves are ignored.
- s_wb_ack_o and s_wb_err_o are never high together.
- s_wb_dat_o is 0 outside ACCESS.

## Timing
- Reset values: state IDLE; s_wb_ack_o=0, s_wb_err_o=0, s_wb_dat_o=0, m_wb_stb_o=0, err_adr_o=0, err_code_o=00, err_count_o=0.
- Decode latency is 1 cycle. For a slave with k-cycle ack latency, master ack arrives k+1 cycles after stb is first seen.
- There is 1 idle turnaround cycle after each completion. Back-to-back accesses therefore cost ≥2 cycles.
- Unmapped access: s_wb_err_o asserts 1 cycle after stb.
- Timeout: s_wb_err_o asserts TIMEOUT_CYCLES+1 cycles after stb.
- If the ack arrives in the same cycle the timer expires, the ack wins: no error is flagged and the count is not incremented.
- A fault while err_count_o=255 updates the address and code, and the count holds at 255.
- Reset asserted mid-access returns to the reset values immediately (asynchronously).

## Configuration
- JELLY_WB_DECODER_TIMEOUT_EN:
  - Defined: the timeout counter and code 10 are built.
  - Undefined: no counter is synthesised; ACCESS waits indefinitely for ack; err_code_o is only ever 00 or 01; TIMEOUT_CYCLES is ignored.

## Test plan
- Settings: SLAVE_NUM=3, ADDR={32'hfffff200,32'h10000000,32'h00000000}, MASK={32'hfffffff0,32'hf0000000,32'hf0000000}, TIMEOUT_CYCLES=8.
- Read at word adr 30'h0000_0004, slave0 acks 2 cycles after its stb with 32'hdeadbeef -> m_wb_stb_o=3'b001; s_wb_ack_o high at cycle 3 after stb with s_wb_dat_o=32'hdeadbeef.
- Write at byte 32'h1000_0010, sel 4'b0011, slave1 acks immediately -> m_wb_stb_o=3'b010, m_wb_sel_o=4'b0011, ack at cycle 1; slave0 and slave2 stb stay low throughout.
- Access at byte 32'h8000_0000 -> s_wb_err_o one cycle at cycle 1; err_code_o=01, err_adr_o=30'h2000_0000, err_count_o=1.
- Slave2 (byte 32'hffff_f204) never acks, macro defined -> s_wb_err_o at cycle 9, m_wb_stb_o drops, err_code_o=10. With macro undefined, stb is held for 1000 cycles and no err occurs.
- Slave2 acks in the exact expiry cycle -> ack only, err_count_o unchanged. Separately: 300 unmapped accesses -> err_count_o=255.
- Assert reset 2 cycles into a slave1 access -> all outputs return to 0 the same cycle; the next access after reset release decodes normally.
